// File: rtl/feedforward_if.sv
// Operand/weight inputs and dot-product result of the feed-forward neuron.
// The master drives x/w and observes result/done; the slave is the neuron datapath.
interface feedforward_if;
  logic [31:0] x1, x2, x3, x4;
  logic [31:0] w1, w2, w3, w4;
  logic [31:0] result;
  logic        done;

  modport master (output x1, x2, x3, x4, w1, w2, w3, w4, input result, done);
  modport slave  (input x1, x2, x3, x4, w1, w2, w3, w4, output result, done);
endinterface

// File: rtl/feedforward.sv
// Free-running binary32 dot product x.w using one shared multiplier and adder; 10 cycles/result.
// No backpressure: inputs are sampled in LOAD only, result is published with a one-cycle done pulse.
module feedforward (
  input  logic         clk,
  input  logic         rst_n,
  feedforward_if.slave bus
);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [3:0] {
    S_LOAD, S_MUL1, S_ADD1, S_MUL2, S_ADD2, S_MUL3, S_ADD3, S_MUL4, S_ADD4, S_OUT
  } state_t;

  state_t             state, state_nxt;
  logic [3:0][31:0]   xr, wr;
  logic [31:0]        prod, acc, result_q;
  logic [31:0]        mul_out, add_out;
  logic               done_q, is_mul, is_add;
  logic [1:0]         sel;

  // value = mag * 2^e0; rounds to 24 significant bits (RNE), then overflow/flush checks
  function automatic logic [31:0] round_pack(input logic s, input logic [63:0] mag, input int e0);
    int          p;
    int          e;
    logic [63:0] m;
    logic [24:0] mant;
    logic [22:0] frac;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    m    = mag << (63 - p);
    e    = p + e0;
    mant = {1'b0, m[63:40]} + 25'(m[39] & ((|m[38:0]) | m[40]));
    frac = mant[24] ? mant[23:1] : mant[22:0];
    if (mant[24]) e = e + 1;
    if (e > 127)  return {s, 8'hFF, 23'h0};
    if (e < -126) return {s, 31'h0};
    return {s, 8'(e + 127), frac};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0] pm;
    s      = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return QNAN;
    if (a_inf || b_inf)   return {s, 8'hFF, 23'h0};
    if (a_zero || b_zero) return {s, 31'h0};
    pm = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    return round_pack(s, {16'h0, pm}, int'(a[30:23]) + int'(b[30:23]) - 300);
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [31:0] big, sml;
    logic [63:0] bm, sm_full, sm, sum;
    int          d;
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return QNAN;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a_zero && b_zero) return {a[31] & b[31], 31'h0};
    if (a_zero) return b;
    if (b_zero) return a;
    if (b[30:0] > a[30:0]) begin big = b; sml = a; end
    else                   begin big = a; sml = b; end
    d       = int'(big[30:23]) - int'(sml[30:23]);
    // 26 extra low bits keep the aligned operand exact for small shifts; bit 0 acts as sticky beyond
    bm      = {14'h0, 1'b1, big[22:0], 26'h0};
    sm_full = {14'h0, 1'b1, sml[22:0], 26'h0};
    if (d >= 63) begin
      sm = 64'd1;
    end else begin
      sm = sm_full >> d;
      if ((sm << d) != sm_full) sm[0] = 1'b1;
    end
    sum = (big[31] == sml[31]) ? bm + sm : bm - sm;
    if (sum == 64'h0) return 32'h0;
    return round_pack(big[31], sum, int'(big[30:23]) - 176);
  endfunction

  always_comb begin
    state_nxt = S_LOAD;
    is_mul    = 1'b0;
    is_add    = 1'b0;
    sel       = 2'd0;
    case (state)
      S_LOAD: state_nxt = S_MUL1;
      S_MUL1: begin state_nxt = S_ADD1; is_mul = 1'b1; sel = 2'd0; end
      S_ADD1: begin state_nxt = S_MUL2; is_add = 1'b1; end
      S_MUL2: begin state_nxt = S_ADD2; is_mul = 1'b1; sel = 2'd1; end
      S_ADD2: begin state_nxt = S_MUL3; is_add = 1'b1; end
      S_MUL3: begin state_nxt = S_ADD3; is_mul = 1'b1; sel = 2'd2; end
      S_ADD3: begin state_nxt = S_MUL4; is_add = 1'b1; end
      S_MUL4: begin state_nxt = S_ADD4; is_mul = 1'b1; sel = 2'd3; end
      S_ADD4: begin state_nxt = S_OUT;  is_add = 1'b1; end
      S_OUT:  state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  assign mul_out = fmul(xr[sel], wr[sel]);
  assign add_out = fadd(acc, prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      xr       <= '0;
      wr       <= '0;
      prod     <= '0;
      acc      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= (state == S_OUT);
      if (state == S_LOAD) begin
        xr  <= {bus.x4, bus.x3, bus.x2, bus.x1};
        wr  <= {bus.w4, bus.w3, bus.w2, bus.w1};
        acc <= 32'h0;
      end
      if (is_mul) prod <= mul_out;
      if (is_add) acc  <= add_out;
      if (state == S_OUT) result_q <= acc;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;
endmodule

// File: tb/tb_feedforward.sv
// Drives directed and random operand sets into feedforward and compares each published
// result against an exact-arithmetic reference that rounds once per operation.
module tb_feedforward;
  typedef logic [299:0]     wide_t;
  typedef logic [3:0][31:0] vec_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   cyc;
  vec_t xa, wa, xb, wb, ones;
  logic [31:0] exp_a, diff;

  feedforward_if bus ();
  feedforward dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // 0 zero (incl. subnormal), 1 normal, 2 inf, 3 nan
  function automatic int kind(input logic [31:0] f);
    if (f[30:23] == 8'h00) return 0;
    if (f[30:23] != 8'hFF) return 1;
    return (f[22:0] == 23'h0) ? 2 : 3;
  endfunction

  function automatic wide_t sig(input logic [31:0] f);
    return wide_t'({1'b1, f[22:0]});
  endfunction

  function automatic int scl(input logic [31:0] f);
    return int'(f[30:23]) - 150;
  endfunction

  // exact value mag * 2^scale rounded to binary32, nearest-even, FTZ
  function automatic logic [31:0] ref_round(input logic s, input wide_t mag, input int scale);
    int    p, e, sh;
    wide_t q, rem, half;
    p = -1;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    e = p + scale;
    if (p > 23) begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = wide_t'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (23 - p);
    end
    if (q == (wide_t'(1) << 24)) begin q = q >> 1; e++; end
    if (e > 127)  return {s, 8'hFF, 23'h0};
    if (e < -126) return {s, 31'h0};
    return {s, 8'(e + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic s;
    s = a[31] ^ b[31];
    if (kind(a) == 3 || kind(b) == 3) return 32'h7FC0_0000;
    if ((kind(a) == 2 && kind(b) == 0) || (kind(a) == 0 && kind(b) == 2)) return 32'h7FC0_0000;
    if (kind(a) == 2 || kind(b) == 2) return {s, 8'hFF, 23'h0};
    if (kind(a) == 0 || kind(b) == 0) return {s, 31'h0};
    return ref_round(s, sig(a) * sig(b), scl(a) + scl(b));
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    int    mn;
    wide_t va, vb;
    if (kind(a) == 3 || kind(b) == 3) return 32'h7FC0_0000;
    if (kind(a) == 2 && kind(b) == 2) return (a[31] == b[31]) ? a : 32'h7FC0_0000;
    if (kind(a) == 2) return a;
    if (kind(b) == 2) return b;
    if (kind(a) == 0 && kind(b) == 0) return {a[31] & b[31], 31'h0};
    if (kind(a) == 0) return b;
    if (kind(b) == 0) return a;
    mn = (scl(a) < scl(b)) ? scl(a) : scl(b);
    va = sig(a) << (scl(a) - mn);
    vb = sig(b) << (scl(b) - mn);
    if (a[31] == b[31]) return ref_round(a[31], va + vb, mn);
    if (va == vb)       return 32'h0;
    if (va > vb)        return ref_round(a[31], va - vb, mn);
    return ref_round(b[31], vb - va, mn);
  endfunction

  function automatic logic [31:0] ref_dot(input vec_t x, input vec_t w);
    logic [31:0] acc;
    acc = 32'h0;
    for (int i = 0; i < 4; i++) acc = ref_add(acc, ref_mul(x[i], w[i]));
    return acc;
  endfunction

  function automatic logic [31:0] rand_f();
    int r;
    r = $urandom_range(0, 31);
    case (r)
      0: return {1'($urandom), 31'h0};
      1: return {1'($urandom), 8'hFF, 23'h0};
      2: return {1'($urandom), 8'hFF, 23'($urandom_range(1, 32'h7F_FFFF))};
      3: return {1'($urandom), 8'h00, 23'($urandom_range(1, 32'h7F_FFFF))};
      4: return {1'($urandom), 8'($urandom_range(230, 254)), 23'($urandom)};
      5: return {1'($urandom), 8'($urandom_range(1, 25)), 23'($urandom)};
      default: return {1'($urandom), 8'($urandom_range(118, 136)), 23'($urandom)};
    endcase
  endfunction

  task automatic set_inputs(input vec_t x, input vec_t w);
    bus.x1 = x[0]; bus.x2 = x[1]; bus.x3 = x[2]; bus.x4 = x[3];
    bus.w1 = w[0]; bus.w2 = w[1]; bus.w3 = w[2]; bus.w4 = w[3];
  endtask

  // counts falling edges until done is seen high, bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 30);
  endtask

  // call while DUT sits in LOAD (done just seen); inputs are captured at the next edge
  task automatic run_vec(input string tag, input vec_t x, input vec_t w);
    int n;
    set_inputs(x, w);
    wait_done(n);
    chk({tag, "_period"}, 32'(n), 32'd10);
    chk({tag, "_result"}, bus.result, ref_dot(x, w));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    ones    = {4{32'h3F80_0000}};
    xa      = {4{32'h4003_3333}};
    wa      = {4{32'h3F82_8F5C}};
    set_inputs(xa, wa);
    repeat (3) @(negedge clk);
    chk("reset_result", bus.result, 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);

    rst_n = 1'b1;
    wait_done(cyc);
    chk("first_latency", 32'(cyc), 32'd10);
    diff = (bus.result > 32'h4105_D2F2) ? bus.result - 32'h4105_D2F2 : 32'h4105_D2F2 - bus.result;
    chk("t1_within_ulp", 32'(diff <= 1), 32'd1);
    chk("t1_model", bus.result, ref_dot(xa, wa));

    xa = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    run_vec("t2", xa, ones);
    chk("t2_const", bus.result, 32'h4120_0000);
    run_vec("t3_cancel", {32'hC000_0000, 32'h4000_0000, 32'hBF80_0000, 32'h3F80_0000}, ones);
    chk("t3_cancel_const", bus.result, 32'h0);
    run_vec("t3_zero", '0, '0);
    chk("t3_zero_const", bus.result, 32'h0);
    xb = xa;
    xb[2] = 32'h7FC0_0000;
    run_vec("t4_nan", xb, ones);
    chk("t4_nan_const", bus.result, 32'h7FC0_0000);
    xb = xa;
    xb[0] = 32'h7F80_0000;
    wb = ones;
    wb[0] = 32'h0;
    run_vec("t4_infzero", xb, wb);
    chk("t4_infzero_const", bus.result, 32'h7FC0_0000);
    exp_a = bus.result;

    // inputs change mid-iteration: current iteration must use the LOAD-time snapshot
    xa = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
    wa = {32'h3F00_0000, 32'h4000_0000, 32'hC040_0000, 32'h3FC0_0000};
    xb = {32'h4120_0000, 32'hC0A0_0000, 32'h3E80_0000, 32'h4210_0000};
    wb = ones;
    set_inputs(xa, wa);
    repeat (3) @(negedge clk);
    set_inputs(xb, wb);
    chk("t5_hold_prev", bus.result, exp_a);
    wait_done(cyc);
    chk("t5_period_rest", 32'(cyc), 32'd7);
    chk("t5_old_inputs", bus.result, ref_dot(xa, wa));
    wait_done(cyc);
    chk("t5_period", 32'(cyc), 32'd10);
    chk("t5_new_inputs", bus.result, ref_dot(xb, wb));

    // reset asserted in ADD3
    set_inputs(xa, ones);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_result", bus.result, 32'h0);
    chk("t6_rst_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(cyc);
    chk("t6_latency", 32'(cyc), 32'd10);
    chk("t6_result", bus.result, ref_dot(xa, ones));

    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < 4; i++) begin
        xa[i] = rand_f();
        wa[i] = rand_f();
      end
      run_vec($sformatf("rand%0d", k), xa, wa);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
